// File: rtl/if_stage_fetchq.sv
// Instruction fetch with a prefetch queue: one fetch per cycle into a circular FIFO, head shown to decode
// combinationally (visible one cycle after push); decode stalls back up only once the queue is full; EX redirect flushes.
module if_stage_fetchq #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int               QUEUE_DEPTH = 4,
    parameter int               INST_BYTES  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ex_take_branch_out,
    input  logic [XLEN-1:0]                    ex_target_PC_out,
    input  logic [XLEN-1:0]                    Imem2proc_data,
    input  logic                               Imem2proc_valid,
    output logic [XLEN-1:0]                    proc2Imem_addr,
    output logic                               proc2Imem_req,
    input  logic                               id_ready,
    output logic                               if_valid_inst_out,
    output logic [XLEN-1:0]                    if_PC_out,
    output logic [XLEN-1:0]                    if_NPC_out,
    output logic [XLEN-1:0]                    if_IR_out,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   if_queue_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] INC     = XLEN'(INST_BYTES);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [XLEN-1:0] ir;
    } entry_t;

    entry_t                  mem [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]  vld;
    logic [XLEN-1:0]         pc_reg;
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    logic [CW-1:0]           count;
    entry_t                  head_entry;
    logic                    pop;
    logic                    can_push;
    logic                    push;

    assign head_entry        = mem[head];
    assign if_valid_inst_out = vld[head];
    assign pop               = if_valid_inst_out & id_ready;
    // A pop in the same cycle frees the slot, so a full queue can still stream.
    assign can_push          = (count < DEPTH_C) | pop;
    assign proc2Imem_req     = ~rst & ~ex_take_branch_out & can_push;
    assign push              = proc2Imem_req & Imem2proc_valid;
    assign proc2Imem_addr    = {pc_reg[XLEN-1:2], 2'b00};

    assign if_PC_out      = if_valid_inst_out ? head_entry.pc  : '0;
    assign if_NPC_out     = if_valid_inst_out ? head_entry.npc : '0;
    assign if_IR_out      = if_valid_inst_out ? head_entry.ir  : '0;
    assign if_queue_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            vld    <= '0;
        end else if (ex_take_branch_out) begin
            pc_reg <= ex_target_PC_out;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (pop) begin
                head      <= head + PW'(1);
                vld[head] <= 1'b0;
            end
            // Set after the clear: at full, push and pop hit the same slot.
            if (push) begin
                tail      <= tail + PW'(1);
                vld[tail] <= 1'b1;
                pc_reg    <= pc_reg + INC;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pc: pc_reg, npc: pc_reg + INC, ir: Imem2proc_data};
        end
    end

endmodule

// File: doc/if_stage_fetchq.md
Name: if_stage_fetchq

Overview:
Parametrised instruction-fetch stage with a prefetch instruction queue between the PC generator and decode. Each cycle it fetches one instruction from instruction memory at the current PC and pushes {PC, NPC, IR} into a circular FIFO when space exists. Decode pops the head through a valid/ready handshake, so decode stalls no longer freeze fetch until the queue is full. A taken branch from EX redirects the PC and flushes the queue in the same cycle.

Parameters:
XLEN, 32, width of PC, NPC and instruction word
RESET_PC, 32'h0, PC value loaded on reset
QUEUE_DEPTH, 4, number of queue entries; power of two, at least 2
INST_BYTES, 4, PC increment per instruction

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
ex_take_branch_out  input  1  redirect request from EX
ex_target_PC_out  input  XLEN  redirect target; valid when ex_take_branch_out=1
Imem2proc_data  input  XLEN  instruction returned for proc2Imem_addr in the same cycle
Imem2proc_valid  input  1  Imem2proc_data is valid this cycle; 0 means an I-miss
proc2Imem_addr  output  XLEN  {PC_reg[XLEN-1:2], 2'b0}
proc2Imem_req  output  1  fetch request this cycle
id_ready  input  1  decode accepts the head entry this cycle
if_valid_inst_out  output  1  head entry is valid (queue not empty)
if_PC_out  output  XLEN  PC of the head entry
if_NPC_out  output  XLEN  PC + INST_BYTES of the head entry
if_IR_out  output  XLEN  instruction of the head entry
if_queue_count  output  $clog2(QUEUE_DEPTH+1)  current occupancy

Behaviour:
- Reset: clock and reset as stated above (clk; rst synchronous active-high).
  - PC_reg=RESET_PC; head, tail and count = 0; all storage valid bits cleared.
  - if_valid_inst_out=0. if_PC_out, if_NPC_out and if_IR_out = 0 while the queue is empty.
  - Reset overrides redirect, push and pop in the same cycle.
- pop = if_valid_inst_out & id_ready.
- can_push = (count < QUEUE_DEPTH) | pop. Simultaneous push and pop at full is allowed.
- proc2Imem_req = ~rst & ~ex_take_branch_out & can_push.
- push = proc2Imem_req & Imem2proc_valid.
  - Writes {PC_reg, PC_reg+INST_BYTES, Imem2proc_data} at tail.
  - tail advances modulo QUEUE_DEPTH.
  - PC_reg <= PC_reg + INST_BYTES. Arithmetic is modulo 2^XLEN and wraps silently.
- No push: PC_reg holds. This covers a full queue with no pop and Imem2proc_valid=0.
- pop: head advances modulo QUEUE_DEPTH.
- count' = count + push - pop; it never exceeds QUEUE_DEPTH and never underflows.
- Head outputs are driven combinationally from storage[head]; an entry becomes visible the cycle after it is pushed.
- Redirect (ex_take_branch_out=1) has priority over push and pop:
  - PC_reg <= ex_target_PC_out.
  - head, tail and count <= 0. All queued entries are discarded, including the entry at the head this cycle.
  - No push that cycle; proc2Imem_req=0.
  - A pop handshake in the redirect cycle is still seen by decode; EX squashes that instruction.
  - First fetch from the target happens in cycle R+1. Its entry is visible at the head in cycle R+2.
- Misaligned targets: the low 2 bits are masked on proc2Imem_addr only. PC_reg and if_PC_out keep the unmasked value.
- Latency: empty queue with memory hit gives fetch at cycle N and head valid at N+1. Steady state is 1 instruction per cycle when id_ready=1.
- Pointer wrap: storage is QUEUE_DEPTH entries; full and empty are distinguished by count.

Test Plan:
- Reset: rst=1 for 2 cycles, then release with Imem valid and id_ready=1 -> proc2Imem_addr 0,4,8,...; if_valid_inst_out first 1 one cycle after release; if_PC_out=0, NPC=4.
- Fill under stall: id_ready=0, Imem valid -> 4 pushes (PC 0,4,8,12); if_queue_count=4; proc2Imem_req=0 with PC_reg=16 held. Set id_ready=1 -> pops in order 0,4,8,12,16 with no bubble.
- Full with simultaneous push/pop: count=4 and id_ready=1 each cycle -> count stays 4 and PC advances by 4 per cycle.
- I-miss: Imem2proc_valid=0 for 3 cycles at PC=8 -> no pushes; PC_reg stays 8; queue drains; entry 8 appears after valid returns.
- Redirect: count=3, ex_take_branch_out=1, target=32'h100 -> next cycle count=0 and valid=0; fetch addr 0x100; head PC=0x100 two cycles after redirect. Redirect together with rst -> PC=RESET_PC.
- Wraparound: 3*QUEUE_DEPTH+1 pushes and pops with id_ready toggling in a 1-0-1-1 pattern -> popped PCs strictly sequential, no loss or duplication; PC wraps 0xFFFFFFFC -> 0x0.
